// File: rtl/maj.sv
`default_nettype none
// ============================================================================
//  Module      : maj
//  Description : Five-replica bitwise majority voter with registered
//                disagreement flags and saturating per-replica error counters.
//  Revision    : 1.0  initial release
// ============================================================================
module maj #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr_cnt,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   c,
    input  logic [WIDTH-1:0]   d,
    input  logic [WIDTH-1:0]   e,
    output logic [WIDTH-1:0]   z,
    output logic [4:0]         mism,
    output logic               unan,
    output logic               fault,
    output logic [5*CNT_W-1:0] err_cnt
);

    localparam int               c_NREP    = 5;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [WIDTH-1:0]  w_rep [c_NREP];
    logic [WIDTH-1:0]  w_vote;
    logic [c_NREP-1:0] w_mism;
    logic [2:0]        w_mism_pop;
    logic              w_all_eq;
    logic              w_unan;
    logic              w_fault;

    logic [WIDTH-1:0]  r_z;
    logic [c_NREP-1:0] r_mism;
    logic              r_unan;
    logic              r_fault;

    assign w_rep[0] = a;
    assign w_rep[1] = b;
    assign w_rep[2] = c;
    assign w_rep[3] = d;
    assign w_rep[4] = e;

    // Per-bit vote: count the ones across replicas, majority is three of five.
    generate
        for (genvar k = 0; k < WIDTH; k++) begin : g_vote
            logic [2:0] w_ones;
            assign w_ones = {2'b00, a[k]} + {2'b00, b[k]} + {2'b00, c[k]}
                          + {2'b00, d[k]} + {2'b00, e[k]};
            assign w_vote[k] = (w_ones >= 3'd3);
        end

        for (genvar i = 0; i < c_NREP; i++) begin : g_mism
            assign w_mism[i] = |(w_rep[i] ^ w_vote);
        end
    endgenerate

    assign w_mism_pop = {2'b00, w_mism[0]} + {2'b00, w_mism[1]} + {2'b00, w_mism[2]}
                      + {2'b00, w_mism[3]} + {2'b00, w_mism[4]};
    assign w_all_eq   = (a == b) && (b == c) && (c == d) && (d == e);
    assign w_unan     = (w_mism == '0) && w_all_eq;
    assign w_fault    = (w_mism_pop >= 3'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_z     <= '0;
            r_mism  <= '0;
            r_unan  <= 1'b0;
            r_fault <= 1'b0;
        end else if (en) begin
            r_z     <= w_vote;
            r_mism  <= w_mism;
            r_unan  <= w_unan;
            r_fault <= w_fault;
        end
    end

    // Counters clear independently of en; increments stop at all-ones.
    generate
        for (genvar i = 0; i < c_NREP; i++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (clr_cnt) begin
                    r_cnt <= '0;
                end else if (en && w_mism[i] && (r_cnt != c_CNT_MAX)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            assign err_cnt[i*CNT_W +: CNT_W] = r_cnt;
        end
    endgenerate

    assign z     = r_z;
    assign mism  = r_mism;
    assign unan  = r_unan;
    assign fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_maj.sv
`default_nettype none
// ============================================================================
//  Module      : tb_maj
//  Description : Self-checking bench for maj (WIDTH=1 and WIDTH=4 instances)
//                against a behavioural voting model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_maj;

    logic clk = 1'b0;
    logic rst, en, clr_cnt;
    logic [4:0] s;                 // WIDTH=1 replicas, {a,b,c,d,e}
    logic [3:0] qa, qb, qc, qd, qe; // WIDTH=4 replicas

    logic [0:0]  z1;
    logic [4:0]  mism1, mism4;
    logic        unan1, fault1, unan4, fault4;
    logic [39:0] err1;
    logic [3:0]  z4;
    logic [19:0] err4;

    int errors = 0;
    int checks = 0;

    // Model state: index 0 = WIDTH=1/CNT_W=8, index 1 = WIDTH=4/CNT_W=4
    logic [3:0] m_z    [2];
    logic [4:0] m_mism [2];
    logic       m_unan [2];
    logic       m_fault[2];
    int         m_cnt  [2][5];
    int         m_max  [2] = '{255, 15};

    always #5 clk = ~clk;

    maj #(.WIDTH(1), .CNT_W(8)) u_maj1 (
        .clk(clk), .rst(rst), .en(en), .clr_cnt(clr_cnt),
        .a(s[4]), .b(s[3]), .c(s[2]), .d(s[1]), .e(s[0]),
        .z(z1), .mism(mism1), .unan(unan1), .fault(fault1), .err_cnt(err1)
    );

    maj #(.WIDTH(4), .CNT_W(4)) u_maj4 (
        .clk(clk), .rst(rst), .en(en), .clr_cnt(clr_cnt),
        .a(qa), .b(qb), .c(qc), .d(qd), .e(qe),
        .z(z4), .mism(mism4), .unan(unan4), .fault(fault4), .err_cnt(err4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Majority of five by counting; mismatch = replica differs from vote anywhere.
    function automatic void vote(input int w, input logic [3:0] r0, r1, r2, r3, r4,
                                 output logic [3:0] vz, output logic [4:0] vm,
                                 output logic vu, output logic vf);
        logic [3:0] r [5];
        int ones, pop;
        r[0] = r0; r[1] = r1; r[2] = r2; r[3] = r3; r[4] = r4;
        vz = '0;
        vm = '0;
        for (int k = 0; k < w; k++) begin
            ones = 0;
            for (int i = 0; i < 5; i++) ones += int'(r[i][k]);
            vz[k] = (ones >= 3);
        end
        pop = 0;
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < w; k++)
                if (r[i][k] != vz[k]) vm[i] = 1'b1;
            if (vm[i]) pop++;
        end
        vu = (vm == 5'b0);
        for (int i = 1; i < 5; i++)
            for (int k = 0; k < w; k++)
                if (r[i][k] != r[0][k]) vu = 1'b0;
        vf = (pop >= 3);
    endfunction

    function automatic void model_edge(input int n, input int w,
                                       input logic [3:0] r0, r1, r2, r3, r4);
        logic [3:0] vz;
        logic [4:0] vm;
        logic vu, vf;
        vote(w, r0, r1, r2, r3, r4, vz, vm, vu, vf);
        if (rst) begin
            m_z[n] = '0; m_mism[n] = '0; m_unan[n] = 1'b0; m_fault[n] = 1'b0;
            for (int i = 0; i < 5; i++) m_cnt[n][i] = 0;
        end else begin
            if (en) begin
                m_z[n] = vz; m_mism[n] = vm; m_unan[n] = vu; m_fault[n] = vf;
            end
            for (int i = 0; i < 5; i++) begin
                if (clr_cnt) m_cnt[n][i] = 0;
                else if (en && vm[i] && m_cnt[n][i] < m_max[n]) m_cnt[n][i]++;
            end
        end
    endfunction

    task automatic tick();
        logic [39:0] x1;
        logic [19:0] x4;
        @(posedge clk);
        model_edge(0, 1, {3'b0, s[4]}, {3'b0, s[3]}, {3'b0, s[2]}, {3'b0, s[1]}, {3'b0, s[0]});
        model_edge(1, 4, qa, qb, qc, qd, qe);
        #1;
        for (int i = 0; i < 5; i++) begin
            x1[i*8 +: 8] = 8'(m_cnt[0][i]);
            x4[i*4 +: 4] = 4'(m_cnt[1][i]);
        end
        chk("w1_z",     64'(z1),     64'(m_z[0][0]));
        chk("w1_mism",  64'(mism1),  64'(m_mism[0]));
        chk("w1_unan",  64'(unan1),  64'(m_unan[0]));
        chk("w1_fault", 64'(fault1), 64'(m_fault[0]));
        chk("w1_cnt",   64'(err1),   64'(x1));
        chk("w4_z",     64'(z4),     64'(m_z[1]));
        chk("w4_mism",  64'(mism4),  64'(m_mism[1]));
        chk("w4_unan",  64'(unan4),  64'(m_unan[1]));
        chk("w4_fault", 64'(fault4), 64'(m_fault[1]));
        chk("w4_cnt",   64'(err4),   64'(x4));
    endtask

    task automatic rand_inputs();
        s  = 5'($urandom);
        qa = 4'($urandom); qb = 4'($urandom); qc = 4'($urandom);
        qd = 4'($urandom); qe = 4'($urandom);
    endtask

    logic [4:0] dir_v [9] = '{5'b00000, 5'b11010, 5'b00001, 5'b10011, 5'b01100,
                              5'b10100, 5'b01101, 5'b01001, 5'b11011};
    logic       dir_z [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [4:0] dir_m [9] = '{5'b00000, 5'b10100, 5'b10000, 5'b00110, 5'b00110,
                              5'b00101, 5'b01001, 5'b10010, 5'b00100};

    initial begin
        rst = 1'b1; en = 1'b0; clr_cnt = 1'b0;
        s = '0; qa = '0; qb = '0; qc = '0; qd = '0; qe = '0;
        for (int n = 0; n < 2; n++) begin
            m_z[n] = 'x; m_mism[n] = 'x; m_unan[n] = 1'bx; m_fault[n] = 1'bx;
            for (int i = 0; i < 5; i++) m_cnt[n][i] = 0;
        end
        tick();
        tick();
        chk("rst_z",    64'(z1),    64'd0);
        chk("rst_mism", 64'(mism1), 64'd0);
        chk("rst_cnt",  64'(err1),  64'd0);

        // Directed WIDTH=1 vectors
        rst = 1'b0; en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            s = dir_v[i];
            rand_inputs_keep_s();
            tick();
            chk("dir_z",    64'(z1),    64'(dir_z[i]));
            chk("dir_mism", 64'(mism1), 64'(dir_m[i]));
            chk("dir_unan", 64'(unan1), 64'(i == 0));
        end

        // WIDTH=4 split vote
        qa = 4'b1010; qb = 4'b1010; qc = 4'b1010; qd = 4'b0101; qe = 4'b0101;
        tick();
        chk("w4_dir_z",     64'(z4),     64'ha);
        chk("w4_dir_mism",  64'(mism4),  64'h18);
        chk("w4_dir_fault", 64'(fault4), 64'd0);

        // Replica e alone disagrees for 300 cycles: counter e saturates
        s = 5'b00001;
        qa = 4'b0000; qb = 4'b0000; qc = 4'b0000; qd = 4'b0000; qe = 4'b0001;
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        repeat (300) tick();
        chk("sat_w1", 64'(err1), {24'd0, 8'd255, 32'd0});
        chk("sat_w4", 64'(err4), {44'd0, 4'd15, 16'd0});

        // Hold with en low, then clear while still disabled
        en = 1'b0;
        repeat (5) begin
            rand_inputs();
            tick();
        end
        chk("hold_cnt",  64'(err1),  {24'd0, 8'd255, 32'd0});
        chk("hold_mism", 64'(mism1), 64'h10);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        chk("clr_w1", 64'(err1), 64'd0);
        chk("clr_w4", 64'(err4), 64'd0);

        // Random traffic with sporadic disable and clear
        repeat (200) begin
            rand_inputs();
            en      = ($urandom_range(0, 9) < 8);
            clr_cnt = ($urandom_range(0, 49) == 0);
            tick();
        end

        // Reset mid-stream with counters loaded
        en = 1'b1; clr_cnt = 1'b0;
        s = 5'b00001;
        repeat (3) tick();
        rst = 1'b1;
        s = 5'b11010;
        tick();
        chk("mid_rst_z",   64'(z1),    64'd0);
        chk("mid_rst_cnt", 64'(err1),  64'd0);
        chk("mid_rst_w4",  64'(err4),  64'd0);
        rst = 1'b0;
        tick();
        chk("resume_z",    64'(z1),    64'd1);
        chk("resume_mism", 64'(mism1), 64'h14);

        repeat (150) begin
            rand_inputs();
            en      = ($urandom_range(0, 9) < 8);
            clr_cnt = ($urandom_range(0, 49) == 0);
            rst     = ($urandom_range(0, 59) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    task automatic rand_inputs_keep_s();
        qa = 4'($urandom); qb = 4'($urandom); qc = 4'($urandom);
        qd = 4'($urandom); qe = 4'($urandom);
    endtask

endmodule
`default_nettype wire

// File: doc/maj.md
MAJ -- requirements
Module: maj

Interface
REQ-001 Parameter WIDTH, default 1: bit width of each voted input and of the voted output; voting is bitwise.
REQ-002 Parameter CNT_W, default 8: width of each per-input mismatch counter.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high, sampled on the rising edge of clk.
REQ-005 en  input  1  vote enable; when low, all registered outputs and counters hold.
REQ-006 clr_cnt  input  1  synchronous clear of all mismatch counters.
REQ-007 a, b, c, d, e  input  WIDTH each  five redundant replica inputs; index order is a=0, b=1, c=2, d=3, e=4.
REQ-008 z  output  WIDTH  registered bitwise majority of a..e.
REQ-009 mism  output  5  registered per-replica mismatch flags; bit i = replica i differs from the vote in at least one bit.
REQ-010 unan  output  1  registered flag; high when all five replicas are identical.
REQ-011 fault  output  1  registered flag; high when at least three replicas mismatch, meaning the vote is unreliable.
REQ-012 err_cnt  output  5*CNT_W  packed saturating mismatch counters; replica i occupies bits [i*CNT_W +: CNT_W].

Function
REQ-013 For each bit position k, the vote SHALL be 1 when three or more of a[k], b[k], c[k], d[k], e[k] are 1, and 0 otherwise.
REQ-014 With en high, z, mism, unan and fault SHALL take the values computed from the current a..e on the next rising clk edge (1-cycle latency).
REQ-015 mism[i] SHALL be the OR-reduction of (replica_i XOR vote) across all WIDTH bits.
REQ-016 unan SHALL equal 1 exactly when mism is 5'b00000 and all replicas are bitwise equal.
REQ-017 fault SHALL equal 1 when the population count of the next mism value is 3 or greater; it cannot exceed 2 when WIDTH=1.
REQ-018 With en high and clr_cnt low, counter i SHALL increment by 1 on each edge where the next mism[i] is 1.
REQ-019 Each counter SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-020 clr_cnt high SHALL zero all counters on that edge regardless of en; z, mism, unan and fault SHALL update normally.
REQ-021 With en low, z, mism, unan, fault and err_cnt SHALL retain their previous values; clr_cnt still applies.
REQ-022 The block SHALL have no combinational path from inputs to outputs.

Reset
REQ-023 When rst is high at a rising clk edge, z SHALL become 0, mism 5'b00000, unan 0, fault 0 and every counter 0.
REQ-024 rst SHALL take priority over en and clr_cnt.
REQ-025 Asserting rst mid-operation SHALL discard the in-flight vote; the first valid output appears one cycle after rst is released and en is high.

Verification
REQ-026 The bench SHALL cover the following directed scenarios (WIDTH=1, en=1, values listed as a,b,c,d,e):
- 00000 -> z=0, mism=00000, unan=1 after 1 cycle; 11010 -> z=1, mism bits c,e set; 00001 -> z=0, mism bit e set.
- 10011 -> z=1; 01100 -> z=0; 10100 -> z=0; 01101 -> z=1; 01001 -> z=0; 11011 -> z=1, mism bit c set.
- Mismatch on replica e only, held for 300 cycles with CNT_W=8 -> counter e=255 (saturated), all other counters 0.
- en low while the inputs change -> all outputs and counters unchanged; clr_cnt pulse -> counters 0 on the next edge.
- rst asserted mid-stream with counters nonzero -> all outputs and counters 0 on the next edge; normal voting resumes after release.
- WIDTH=4, a=b=c=1010, d=e=0101 -> z=1010, mism=11000, fault=0.
